// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: four-digit common-anode display scanner.
// Each digit slot starts with a blanking gap to stop ghosting between digits.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   segments_in     packed active-low patterns, digit n = [7n+6:7n]
//   digit_enable_in per-digit enable, bit n = digit n
//   seg_out         active-low cathodes {g..a}
//   anode_out       active-low anode selects, bit 0 = rightmost digit
//   frame_tick_out  one-cycle pulse as the outputs enter digit-0 blanking
//
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading
// zero digits (3, 2, 1) that match ZERO_PAT in the frame snapshot.
module seven_seg_scanner #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned DIGIT_HZ     = 1000,
    parameter int unsigned BLANK_CYCLES = 2000,
    parameter logic [6:0]  ZERO_PAT     = 7'b1000000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [27:0] segments_in,
    input  logic [3:0]  digit_enable_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  anode_out,
    output logic        frame_tick_out
);

    localparam int unsigned DIV   = CLK_HZ / DIGIT_HZ;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] TICK_MAX  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    if (DIV < 2) begin : g_div_chk
        $error("seven_seg_scanner: DIV must be at least 2");
    end
    if (BLANK_CYCLES >= DIV) begin : g_blank_chk
        $error("seven_seg_scanner: BLANK_CYCLES must be below DIV");
    end

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       digit_idx;
    logic [0:0]       state;
    logic             wrap;
    logic             take;
    logic [27:0]      snap_seg;
    logic [3:0]       snap_en;
    logic [27:0]      seg_eff;
    logic [3:0]       en_eff;
    logic [3:0]       en_act;
    logic [6:0]       pat;

    assign wrap  = (tick_cnt == TICK_MAX);
    assign take  = (digit_idx == 2'd0) && (tick_cnt == '0);
    // Phase is a pure function of the prescaler, so no separate state flop.
    assign state = (tick_cnt < BLANK_END) ? BLANK : DRIVE;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (wrap) begin
            tick_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            snap_seg <= 28'hFFFFFFF;
            snap_en  <= 4'b0000;
        end else if (take) begin
            snap_seg <= segments_in;
            snap_en  <= digit_enable_in;
        end
    end

    // Bypass the snapshot in the latch cycle so a zero-length blank
    // would still show this frame's data on digit 0.
    assign seg_eff = take ? segments_in : snap_seg;
    assign en_eff  = take ? digit_enable_in : snap_en;

`ifdef LEADING_ZERO_BLANK_EN
    logic sup3;
    logic sup2;
    logic sup1;

    assign sup3   = (seg_eff[27:21] == ZERO_PAT);
    assign sup2   = sup3 && (seg_eff[20:14] == ZERO_PAT);
    assign sup1   = sup2 && (seg_eff[13:7] == ZERO_PAT);
    assign en_act = en_eff & ~{sup3, sup2, sup1, 1'b0};
`else
    logic zero_pat_unused;

    assign zero_pat_unused = ^ZERO_PAT;
    assign en_act          = en_eff;
`endif

    always_comb begin
        pat = 7'h7F;
        unique case (digit_idx)
            2'd0: pat = seg_eff[6:0];
            2'd1: pat = seg_eff[13:7];
            2'd2: pat = seg_eff[20:14];
            2'd3: pat = seg_eff[27:21];
            default: pat = 7'h7F;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            seg_out        <= 7'h7F;
            anode_out      <= 4'b1111;
            frame_tick_out <= 1'b0;
        end else begin
            frame_tick_out <= take;
            if ((state == DRIVE) && en_act[digit_idx]) begin
                anode_out <= ~(4'b0001 << digit_idx);
                seg_out   <= pat;
            end else begin
                anode_out <= 4'b1111;
                seg_out   <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed bench for seven_seg_scanner.
// DIV = 40/4 = 10 cycles per slot, 2 blank cycles per slot.
module tb_seven_seg_scanner;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic [27:0] segments_in = 28'h0;
    logic [3:0]  digit_enable_in = 4'hF;
    logic [6:0]  seg_out;
    logic [3:0]  anode_out;
    logic        frame_tick_out;

    int total = 0;
    int bad = 0;

    localparam logic [6:0] P0 = 7'h40;
    localparam logic [6:0] P1 = 7'h79;
    localparam logic [6:0] P2 = 7'h24;
    localparam logic [6:0] P3 = 7'h30;
    localparam logic [6:0] P4 = 7'h19;
    localparam logic [6:0] P5 = 7'h12;
    localparam logic [6:0] P6 = 7'h02;
    localparam logic [6:0] P7 = 7'h78;
    localparam logic [6:0] P8 = 7'h00;

    logic [3:0] an_tbl  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] old_tbl [0:3] = '{P1, P2, P3, P4};
    logic [6:0] new_tbl [0:3] = '{P5, P6, P7, P8};

    seven_seg_scanner #(
        .CLK_HZ(40),
        .DIGIT_HZ(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .segments_in(segments_in),
        .digit_enable_in(digit_enable_in),
        .seg_out(seg_out),
        .anode_out(anode_out),
        .frame_tick_out(frame_tick_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic restart(input logic [27:0] segs, input logic [3:0] en);
        segments_in = segs;
        digit_enable_in = en;
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n_in = 1'b0;
        #1;
        total++;
        if (anode_out !== 4'b1111) begin
            bad++;
            $display("FAIL reset_anode got=%b want=1111", anode_out);
        end
        @(posedge clk_in);
        #1;
        total++;
        if (seg_out !== 7'h7F) begin
            bad++;
            $display("FAIL reset_seg got=%h want=7f", seg_out);
        end
        total++;
        if (frame_tick_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_tick got=%b want=0", frame_tick_out);
        end
    endtask

    task automatic test_zero_scan();
        int d;
        int t;
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        restart(28'h0, 4'hF);
        for (int p = 0; p < 80; p++) begin
            @(posedge clk_in);
            #1;
            d = (p / 10) % 4;
            t = p % 10;
            ea = (t < 2) ? 4'hF : an_tbl[d];
            es = (t < 2) ? 7'h7F : 7'h00;
            ef = ((p % 40) == 0);
            total++;
            if (anode_out !== ea) begin
                bad++;
                $display("FAIL zero_anode p=%0d got=%b want=%b", p, anode_out, ea);
            end
            total++;
            if (seg_out !== es) begin
                bad++;
                $display("FAIL zero_seg p=%0d got=%h want=%h", p, seg_out, es);
            end
            total++;
            if (frame_tick_out !== ef) begin
                bad++;
                $display("FAIL zero_tick p=%0d got=%b want=%b", p, frame_tick_out, ef);
            end
        end
    endtask

    task automatic test_patterns();
        int d;
        int t;
        logic [3:0] ea;
        logic [6:0] es;
        restart({P4, P3, P2, P1}, 4'hF);
        for (int p = 0; p < 80; p++) begin
            @(posedge clk_in);
            #1;
            d = (p / 10) % 4;
            t = p % 10;
            ea = (t < 2) ? 4'hF : an_tbl[d];
            es = (t < 2) ? 7'h7F : ((p < 40) ? old_tbl[d] : new_tbl[d]);
            total++;
            if (anode_out !== ea) begin
                bad++;
                $display("FAIL pat_anode p=%0d got=%b want=%b", p, anode_out, ea);
            end
            total++;
            if (seg_out !== es) begin
                bad++;
                $display("FAIL pat_seg p=%0d got=%h want=%h", p, seg_out, es);
            end
            if (p == 15) segments_in = {P8, P7, P6, P5};
        end
    endtask

    task automatic test_enable();
        int d;
        int t;
        logic [3:0] en;
        logic [3:0] ea;
        logic [6:0] es;
        en = 4'b0101;
        restart({P4, P3, P2, P1}, en);
        for (int p = 0; p < 40; p++) begin
            @(posedge clk_in);
            #1;
            d = p / 10;
            t = p % 10;
            ea = (t < 2 || !en[d]) ? 4'hF : an_tbl[d];
            es = (t < 2 || !en[d]) ? 7'h7F : old_tbl[d];
            total++;
            if (anode_out !== ea) begin
                bad++;
                $display("FAIL en_anode p=%0d got=%b want=%b", p, anode_out, ea);
            end
            total++;
            if (seg_out !== es) begin
                bad++;
                $display("FAIL en_seg p=%0d got=%h want=%h", p, seg_out, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea;
        logic [6:0] es;
        restart({P4, P3, P2, P1}, 4'hF);
        repeat (26) @(posedge clk_in);
        #1;
        total++;
        if (anode_out !== 4'b1011 || seg_out !== P3) begin
            bad++;
            $display("FAIL mid_pre got=%b/%h want=1011/%h", anode_out, seg_out, P3);
        end
        #3 rst_n_in = 1'b0;
        #1;
        total++;
        if (anode_out !== 4'b1111) begin
            bad++;
            $display("FAIL mid_async_anode got=%b want=1111", anode_out);
        end
        total++;
        if (seg_out !== 7'h7F) begin
            bad++;
            $display("FAIL mid_async_seg got=%h want=7f", seg_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int p = 0; p < 12; p++) begin
            @(posedge clk_in);
            #1;
            ea = (p < 2 || p >= 10) ? 4'hF : 4'b1110;
            es = (p < 2 || p >= 10) ? 7'h7F : P1;
            total++;
            if (anode_out !== ea || seg_out !== es) begin
                bad++;
                $display("FAIL mid_restart p=%0d got=%b/%h want=%b/%h",
                         p, anode_out, seg_out, ea, es);
            end
            total++;
            if (frame_tick_out !== (p == 0)) begin
                bad++;
                $display("FAIL mid_tick p=%0d got=%b", p, frame_tick_out);
            end
        end
    endtask

    task automatic test_lzb();
        int d;
        int t;
        logic [3:0] lit;
        logic [6:0] tbl [0:3];
        logic [3:0] ea;
        logic [6:0] es;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                tbl = '{P0, P4, P0, P0};
`ifdef LEADING_ZERO_BLANK_EN
                lit = 4'b0011;
`else
                lit = 4'b1111;
`endif
            end else begin
                tbl = '{P0, P0, P0, P0};
`ifdef LEADING_ZERO_BLANK_EN
                lit = 4'b0001;
`else
                lit = 4'b1111;
`endif
            end
            restart({tbl[3], tbl[2], tbl[1], tbl[0]}, 4'hF);
            for (int p = 0; p < 40; p++) begin
                @(posedge clk_in);
                #1;
                d = p / 10;
                t = p % 10;
                ea = (t < 2 || !lit[d]) ? 4'hF : an_tbl[d];
                es = (t < 2 || !lit[d]) ? 7'h7F : tbl[d];
                total++;
                if (anode_out !== ea || seg_out !== es) begin
                    bad++;
                    $display("FAIL lzb r=%0d p=%0d got=%b/%h want=%b/%h",
                             r, p, anode_out, seg_out, ea, es);
                end
            end
        end
    endtask

    task automatic test_scan_rules();
        logic [3:0] last_an;
        int gap;
        bit have_last;
        last_an = 4'hF;
        gap = 0;
        have_last = 0;
        restart(28'h1234567, 4'hF);
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk_in);
            #1;
            total++;
            if ($countones(~anode_out) > 1) begin
                bad++;
                $display("FAIL one_hot c=%0d got=%b want<=1 low", c, anode_out);
            end
            if (anode_out == 4'hF) begin
                gap++;
            end else begin
                if (have_last && anode_out != last_an) begin
                    total++;
                    if (gap < 2) begin
                        bad++;
                        $display("FAIL gap c=%0d got=%0d want>=2", c, gap);
                    end
                end
                last_an = anode_out;
                have_last = 1;
                gap = 0;
            end
            if ((c % 37) == 36) begin
                segments_in = 28'($urandom);
                digit_enable_in = 4'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_scan();
        test_patterns();
        test_enable();
        test_reset_mid();
        test_lzb();
        test_scan_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
